// File: rtl/ex_mem_skid_pkg.sv
// rtl/ex_mem_skid_pkg.sv - shared core types and constants for the EX->MEM boundary
package ex_mem_skid_pkg;

    localparam logic [31:0] DATA_INVALID = 32'h0000_0000;
    localparam logic [31:0] ADDR_INVALID = 32'h0000_0000;

    localparam int EXCEPT_TYPE_W = 6;

    // except_type is the last (least significant) field so the top can test it with a plain slice.
    typedef struct packed {
        logic [31:0]              inst;
        logic [31:0]              pc;
        logic [31:0]              alu_result;
        logic [31:0]              lsu_data;
        logic [3:0]               lsu_op;
        logic [4:0]               rw_addr;
        logic                     rw_en;
        logic                     csr_rw_en;
        logic [13:0]              csr_rw_addr;
        logic [31:0]              csr_rw_data;
        logic [31:0]              except_pc;
        logic [EXCEPT_TYPE_W-1:0] except_type;
    } ex_mem_payload_t;

    localparam logic [31:0]              INST_ZERO        = '0;
    localparam logic [31:0]              PC_ZERO          = '0;
    localparam logic [31:0]              ALU_RESULT_ZERO  = '0;
    localparam logic [31:0]              LSU_DATA_ZERO    = '0;
    localparam logic [3:0]               LSU_OP_ZERO      = '0;
    localparam logic [4:0]               RW_ADDR_ZERO     = '0;
    localparam logic                     RW_EN_ZERO       = 1'b0;
    localparam logic                     CSR_RW_EN_ZERO   = 1'b0;
    localparam logic [13:0]              CSR_RW_ADDR_ZERO = '0;
    localparam logic [31:0]              CSR_RW_DATA_ZERO = '0;
    localparam logic [31:0]              EXCEPT_PC_ZERO   = '0;
    localparam logic [EXCEPT_TYPE_W-1:0] EXCEPT_TYPE_ZERO = '0;

    localparam ex_mem_payload_t EX_MEM_PAYLOAD_ZERO = '{
        inst:        INST_ZERO,
        pc:          PC_ZERO,
        alu_result:  ALU_RESULT_ZERO,
        lsu_data:    LSU_DATA_ZERO,
        lsu_op:      LSU_OP_ZERO,
        rw_addr:     RW_ADDR_ZERO,
        rw_en:       RW_EN_ZERO,
        csr_rw_en:   CSR_RW_EN_ZERO,
        csr_rw_addr: CSR_RW_ADDR_ZERO,
        csr_rw_data: CSR_RW_DATA_ZERO,
        except_pc:   EXCEPT_PC_ZERO,
        except_type: EXCEPT_TYPE_ZERO
    };

endpackage

// File: rtl/ex_mem_skid_buf.sv
// rtl/ex_mem_skid_buf.sv - generic two-entry (main + skid) payload buffer
module skid_buf_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] main_data,
    output logic             main_valid,
    output logic             skid_full
);

    logic [WIDTH-1:0] skid_data;

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            main_data  <= '0;
            skid_data  <= '0;
            main_valid <= 1'b0;
            skid_full  <= 1'b0;
        end else if (pop) begin
            if (skid_full) begin
                // Skid refills main; a simultaneous push lands in the freed skid slot.
                main_data <= skid_data;
                if (push) begin
                    skid_data <= push_data;
                end else begin
                    skid_data <= '0;
                    skid_full <= 1'b0;
                end
            end else if (push) begin
                main_data <= push_data;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (push) begin
            if (!main_valid) begin
                main_data  <= push_data;
                main_valid <= 1'b1;
            end else if (!skid_full) begin
                skid_data <= push_data;
                skid_full <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX->MEM pipeline register with skid slot, stall/flush and exception blocking
module ex_mem_skid
    import ex_mem_skid_pkg::*;
#(
    parameter int PAYLOAD_W = $bits(ex_mem_payload_t)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ls_valid,
    output logic                 ts_ready,
    input  logic [PAYLOAD_W-1:0] ex_payload,
    output logic                 ts_valid,
    input  logic                 ns_ready,
    output logic [PAYLOAD_W-1:0] mem_payload,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 except_pending
);

    logic main_valid;
    logic skid_full;
    logic except_block;
    logic push;
    logic pop;
    logic exc_hit;

    assign exc_hit  = |ex_payload[EXCEPT_TYPE_W-1:0];
    // Ready depends only on registered state and stall, never on ns_ready.
    assign ts_ready = !skid_full && !stall && !except_block;
    assign ts_valid = main_valid && !stall;
    assign push     = ls_valid && ts_ready;
    assign pop      = ts_valid && ns_ready;

    skid_buf_2 #(
        .WIDTH(PAYLOAD_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .clear     (flush),
        .push      (push),
        .pop       (pop),
        .push_data (ex_payload),
        .main_data (mem_payload),
        .main_valid(main_valid),
        .skid_full (skid_full)
    );

    // Once an excepting instruction is accepted, nothing younger enters until flush.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            except_block <= 1'b0;
        end else if (push && exc_hit) begin
            except_block <= 1'b1;
        end
    end

    assign except_pending = except_block;

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - self-checking bench for ex_mem_skid
module tb_ex_mem_skid;
    import ex_mem_skid_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            ls_valid;
    logic            ts_ready;
    ex_mem_payload_t ex_payload;
    logic            ts_valid;
    logic            ns_ready;
    ex_mem_payload_t mem_payload;
    logic            stall;
    logic            flush;
    logic            except_pending;

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_payload_t m_q[$];
    bit              m_exc = 1'b0;
    bit              m_clr = 1'b1;
    bit              m_on  = 1'b0;

    always #5 clk = ~clk;

    ex_mem_skid dut (
        .clk           (clk),
        .rst           (rst),
        .ls_valid      (ls_valid),
        .ts_ready      (ts_ready),
        .ex_payload    (ex_payload),
        .ts_valid      (ts_valid),
        .ns_ready      (ns_ready),
        .mem_payload   (mem_payload),
        .stall         (stall),
        .flush         (flush),
        .except_pending(except_pending)
    );

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, got, exp);
        end
    endtask

    function automatic ex_mem_payload_t mk(input logic [31:0] pc, input logic [5:0] exc);
        ex_mem_payload_t p;
        p             = '0;
        p.inst        = pc ^ 32'hA5A5_0F0F;
        p.pc          = pc;
        p.alu_result  = pc + 32'h10;
        p.lsu_data    = ~pc;
        p.lsu_op      = pc[5:2];
        p.rw_addr     = pc[6:2];
        p.rw_en       = pc[2];
        p.csr_rw_en   = pc[3];
        p.csr_rw_addr = pc[15:2];
        p.csr_rw_data = {pc[15:0], pc[31:16]};
        p.except_pc   = (exc != 0) ? pc : 32'h0;
        p.except_type = exc;
        return p;
    endfunction

    // Reference: a FIFO of at most two accepted payloads, plus a sticky exception flag.
    always @(posedge clk) begin
        bit can_push;
        bit can_pop;
        can_push = ls_valid && (m_q.size() < 2) && !stall && !m_exc;
        can_pop  = (m_q.size() > 0) && !stall && ns_ready;
        if (!rst || flush) begin
            m_q.delete();
            m_exc = 1'b0;
            m_clr = 1'b1;
        end else begin
            if (can_pop) void'(m_q.pop_front());
            if (can_push) begin
                m_q.push_back(ex_payload);
                m_clr = 1'b0;
                if (ex_payload.except_type != 0) m_exc = 1'b1;
            end
        end
        m_on = 1'b1;
    end

    always @(negedge clk) begin
        if (m_on) begin
            chk("model ts_valid", ts_valid, (m_q.size() > 0) && !stall);
            chk("model ts_ready", ts_ready, (m_q.size() < 2) && !stall && !m_exc);
            chk("model except_pending", except_pending, m_exc);
            if (m_q.size() > 0) chk("model mem_payload", mem_payload, m_q[0]);
            else if (m_clr)     chk("model mem_payload zero", mem_payload, '0);
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input bit v, input logic [31:0] pc, input logic [5:0] exc);
        ls_valid   = v;
        ex_payload = mk(pc, exc);
    endtask

    initial begin
        rst = 1'b0; ls_valid = 1'b0; ex_payload = '0;
        ns_ready = 1'b1; stall = 1'b0; flush = 1'b0;
        nxt(); nxt();
        @(negedge clk);
        chk("reset ts_valid", ts_valid, 1'b0);
        chk("reset ts_ready", ts_ready, 1'b1);
        chk("reset mem_payload", mem_payload, '0);
        chk("reset except_pending", except_pending, 1'b0);
        nxt();
        rst = 1'b1;

        // Single transfer with one-cycle latency
        drv(1, 32'h1C00_0000, 0);
        nxt();
        drv(0, 0, 0);
        @(negedge clk);
        chk("first ts_valid", ts_valid, 1'b1);
        chk("first pc", mem_payload.pc, 32'h1C00_0000);
        chk("first ts_ready", ts_ready, 1'b1);
        nxt();

        // Fill both entries while MEM is blocked
        ns_ready = 1'b0;
        drv(1, 32'h100, 0); nxt();
        drv(1, 32'h104, 0); nxt();
        drv(0, 0, 0);
        @(negedge clk);
        chk("full ts_ready", ts_ready, 1'b0);
        chk("full head pc", mem_payload.pc, 32'h100);
        nxt();

        // Stall while full freezes everything
        stall = 1'b1; ns_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall ts_valid", ts_valid, 1'b0);
            chk("stall ts_ready", ts_ready, 1'b0);
            nxt();
        end
        stall = 1'b0;
        @(negedge clk);
        chk("drain0 pc", mem_payload.pc, 32'h100);
        nxt();
        @(negedge clk);
        chk("drain1 pc", mem_payload.pc, 32'h104);
        chk("drain1 ts_valid", ts_valid, 1'b1);
        nxt();
        @(negedge clk);
        chk("drained ts_valid", ts_valid, 1'b0);
        nxt();

        // Exception blocks younger instructions until flush
        ns_ready = 1'b0;
        drv(1, 32'h200, 6'h8); nxt();
        drv(1, 32'h204, 0);
        repeat (3) begin
            @(negedge clk);
            chk("exc ts_ready", ts_ready, 1'b0);
            chk("exc pending", except_pending, 1'b1);
            nxt();
        end
        ns_ready = 1'b1;
        @(negedge clk);
        chk("exc head pc", mem_payload.pc, 32'h200);
        nxt();
        @(negedge clk);
        chk("exc younger absent", ts_valid, 1'b0);
        nxt();
        drv(0, 0, 0);
        flush = 1'b1; nxt();
        flush = 1'b0;
        @(negedge clk);
        chk("flush except_pending", except_pending, 1'b0);
        chk("flush ts_ready", ts_ready, 1'b1);
        nxt();

        // Flush with a simultaneous push at count 2
        ns_ready = 1'b0;
        drv(1, 32'h300, 0); nxt();
        drv(1, 32'h304, 0); nxt();
        drv(1, 32'h308, 0); flush = 1'b1; nxt();
        drv(0, 0, 0); flush = 1'b0;
        @(negedge clk);
        chk("flushpush ts_valid", ts_valid, 1'b0);
        chk("flushpush mem_payload", mem_payload, '0);
        ns_ready = 1'b1; nxt();
        @(negedge clk);
        chk("flushpush still empty", ts_valid, 1'b0);
        nxt();

        // Back-to-back stream exercising push+pop at count 1
        for (int i = 0; i < 6; i++) begin
            drv(1, 32'h500 + 32'(4 * i), 0);
            @(negedge clk);
            if (i > 0) chk("stream pc", mem_payload.pc, 32'h500 + 32'(4 * (i - 1)));
            nxt();
        end
        drv(0, 0, 0);
        nxt(); nxt();

        // Flush wins over stall
        ns_ready = 1'b0;
        drv(1, 32'h600, 0); nxt();
        drv(0, 0, 0); stall = 1'b1; flush = 1'b1; nxt();
        stall = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("stallflush ts_valid", ts_valid, 1'b0);
        nxt();

        // Reset mid-operation with both entries occupied; reset beats flush
        drv(1, 32'h400, 0); nxt();
        drv(1, 32'h404, 6'h3); nxt();
        drv(0, 0, 0);
        rst = 1'b0; flush = 1'b1; ns_ready = 1'b1; nxt();
        rst = 1'b1; flush = 1'b0;
        @(negedge clk);
        chk("rst ts_valid", ts_valid, 1'b0);
        chk("rst mem_payload", mem_payload, '0);
        chk("rst ts_ready", ts_ready, 1'b1);
        chk("rst except_pending", except_pending, 1'b0);
        nxt(); nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_skid.md
EX_MEM_SKID -- requirements
Module: ex_mem_skid

Interface
REQ-001 Parameter PAYLOAD_W, default $bits(ex_mem_payload_t), width of the EX->MEM payload.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset; synchronous and active-low (0 = reset asserted, sampled on posedge clk).
REQ-004 ls_valid  input  1  EX stage holds a valid instruction.
REQ-005 ts_ready  output  1  this block accepts a payload this cycle.
REQ-006 ex_payload  input  PAYLOAD_W  inst, pc, alu_result, lsu_data, lsu_op, rw_addr, rw_en, csr rw_en/rw_addr/rw_data, except_type, except_pc.
REQ-007 ts_valid  output  1  mem_payload is valid for MEM.
REQ-008 ns_ready  input  1  MEM accepts mem_payload this cycle.
REQ-009 mem_payload  output  PAYLOAD_W  oldest buffered payload.
REQ-010 stall  input  1  global hold from hazard unit.
REQ-011 flush  input  1  discard all buffered payloads.
REQ-012 except_pending  output  1  an accepted payload with nonzero except_type is still buffered or was forwarded since the last flush.

Function
REQ-013 Storage SHALL be two entries: main (drives mem_payload) and skid; occupancy count 0..2.
REQ-014 Upstream transfer SHALL occur iff ls_valid && ts_ready; downstream transfer iff ts_valid && ns_ready.
REQ-015 ts_ready SHALL equal !skid_full && !stall && !except_block, with skid_full and except_block taken from registers only (no combinational path from ns_ready).
REQ-016 ts_valid SHALL equal main_valid && !stall.
REQ-017 Latency SHALL be one cycle: payload accepted in cycle N with block empty appears on mem_payload with ts_valid=1 in cycle N+1.
REQ-018 Order SHALL be FIFO; skid entry moves to main in the same cycle main is popped.
REQ-019 Count 1, push and pop in the same cycle: main SHALL load the new payload, count stays 1.
REQ-020 Count 1, push without pop: new payload SHALL go to skid, count 2, ts_ready 0 from next cycle.
REQ-021 Count 2: no push possible; pop moves skid to main, count 1, ts_ready 1 next cycle if not stalled/blocked.
REQ-022 stall=1 SHALL freeze all entries and count; no push, no pop.
REQ-023 flush SHALL have priority over stall, push and pop: next cycle count=0, ts_valid=0, except_block=0, except_pending=0, entries cleared to zero.
REQ-024 Accepting a payload with except_type != 0 SHALL set except_block and except_pending next cycle; both hold until flush; younger payloads are refused (ts_ready=0).
REQ-025 Flush and push in the same cycle: push SHALL be dropped.
REQ-026 Invalid cycles (ls_valid=0) SHALL never alter entries.

Reset
REQ-027 While rst=0 at posedge clk: count=0, main/skid cleared to zero, except_block=0; outputs ts_valid=0, except_pending=0, mem_payload=0, ts_ready=1 when stall=0.
REQ-028 Reset mid-operation SHALL discard all entries with no downstream transfer in the following cycle.
REQ-029 Reset SHALL take priority over flush.

Structure
REQ-030 ex_mem_payload_t (packed struct) and zero constants for each field SHALL live in the shared core package beside existing DATA/ADDR invalid constants.
REQ-031 One sub-module skid_buf_2 (generic 2-entry payload buffer, WIDTH param) is natural; exception blocking stays in ex_mem_skid.
REQ-032 Implementation target 120-400 lines RTL.

Verification
REQ-033 After reset, ls_valid=1, pc=0x1C000000, ns_ready=1 -> ts_valid=1 next cycle, mem_payload.pc=0x1C000000, ts_ready stays 1.
REQ-034 ns_ready=0, push pc=0x100 then 0x104 -> count 2, ts_ready=0; ns_ready=1 -> 0x100 then 0x104 emitted on consecutive cycles, no loss or duplication.
REQ-035 Count 2, stall=1 for 3 cycles with ns_ready=1 -> ts_valid=0, ts_ready=0, contents unchanged; release -> 0x100 emitted first.
REQ-036 Push except_type=0x8 pc=0x200, then ls_valid=1 pc=0x204 -> ts_ready=0, 0x204 never accepted, except_pending=1; flush -> except_pending=0, ts_ready=1 next cycle.
REQ-037 Count 2 with flush=1 and ls_valid=1 same cycle -> next cycle ts_valid=0, count 0, pushed payload absent.
REQ-038 rst=0 asserted with count 2 -> next cycle ts_valid=0, mem_payload=0; rst=1 -> ts_ready=1.
